sha_digest_uart_serializer: RTL and testbench
=============================================

# sha_digest_uart_serializer

Upstream feeder for the UART transmitter. It accepts a completed SHA-256 digest and streams it out one byte at a time over the transmitter's `i_Tx_DV` / `i_Tx_Byte` / `o_Tx_Done` handshake. Each byte is sent either raw or as lowercase ASCII hex, with an optional CR/LF terminator. It sits between the hash core's digest output and `uart_tx`, and provides a single-word valid/ready input so the core can hand off a result and move on.

## Interface
Parameters:
- `DIGEST_WIDTH`, 256, digest bits; must be a multiple of 8.
- `UART_DATA_WIDTH`, 8, byte width to the transmitter.
- `HEX_ASCII`, 1, 1 = two ASCII hex chars per byte; 0 = raw bytes.
- `APPEND_CRLF`, 1, 1 = send 0x0D then 0x0A after the digest.

Ports:
- `i_Clock`, in, 1, sole clock.
- `i_Rst_n`, in, 1, asynchronous active-low reset.
- `i_Digest_Valid`, in, 1, digest available.
- `i_Digest`, in, DIGEST_WIDTH, digest; bit [DIGEST_WIDTH-1] is the MSB of byte 0.
- `o_Digest_Ready`, out, 1, high only in IDLE.
- `o_Tx_DV`, out, 1, one-cycle start pulse to the transmitter.
- `o_Tx_Byte`, out, UART_DATA_WIDTH, byte to the transmitter.
- `i_Tx_Active`, in, 1, transmitter busy.
- `i_Tx_Done`, in, 1, transmitter done flag; may stay high for 2 cycles.
- `o_Busy`, out, 1, high from capture until frame end.
- `o_Frame_Done`, out, 1, one-cycle pulse after the last byte's `i_Tx_Done` clears.

## Operation
- Reset (asynchronous, any state): state = IDLE, shift register = 0, char counter = 0.
  - `o_Tx_DV`=0, `o_Tx_Byte`=0, `o_Busy`=0, `o_Frame_Done`=0.
  - `o_Digest_Ready`=1 once reset deasserts.
- Frame length N:
  - Raw payload: DIGEST_WIDTH/8 chars (32). Hex payload: DIGEST_WIDTH/4 chars (64).
  - Add 2 if `APPEND_CRLF`. Defaults give N = 66.
  - The char counter is 7 bits minimum and counts 0..N-1.
- States and transitions:
  - IDLE: Ready=1. On Valid & Ready, capture `i_Digest` into the shift register, clear the counter, set Busy, go to LOAD.
  - LOAD: form the char and drive `o_Tx_Byte` with it.
    - Hex mode: current nibble n (high nibble first) maps to 0x30+n if n<10, else 0x57+n ('a'..'f').
    - Payload exhausted: 0x0D, then 0x0A.
    - Go to SEND.
  - SEND: `o_Tx_DV`=1 for exactly this cycle; go to WAIT_DONE.
  - WAIT_DONE: hold until `i_Tx_Done`=1, then go to WAIT_IDLE.
  - WAIT_IDLE: hold until `i_Tx_Done`=0 and `i_Tx_Active`=0, which guarantees the transmitter is back in its idle state.
    - Then advance: raw shifts 8 bits; hex shifts 4 bits per char. Increment the counter.
    - If the counter reached N-1, go to FINISH; else go to LOAD.
  - FINISH: pulse `o_Frame_Done`, clear Busy, go to IDLE.
- Input behaviour:
  - Valid is ignored while Ready=0. No queuing; the upstream holds Valid.
  - `i_Tx_Done` or `i_Tx_Active` activity outside the WAIT states is ignored.
- `o_Tx_Byte` is stable from LOAD until WAIT_IDLE exits.

## Timing
- Capture edge = cycle 0. LOAD = cycle 1. `o_Tx_DV` is high in cycle 2.
- Inter-byte gap:
  - The next DV comes 2 cycles after `i_Tx_Done` is observed low (one cycle WAIT_IDLE→LOAD, one cycle LOAD→SEND).
  - This is always inside transmitter IDLE, so no DV pulse is ever lost.
- `o_Frame_Done` asserts 1 cycle after the final WAIT_IDLE exit.
- `o_Digest_Ready` returns high in the cycle after `o_Frame_Done`.
- The next capture is possible on that cycle: back-to-back frames have a 1-cycle Ready gap.
- Reset mid-frame:
  - `o_Tx_DV` drops immediately.
  - A byte already started by the transmitter completes on the line; this block does not wait for it.

## Test plan
- SHA-256("abc") digest ba7816bf…f20015ad, defaults → 66 DV pulses with bytes 0x62,0x61,0x37,0x38,… ending 0x61,0x64,0x0D,0x0A; exactly one `o_Frame_Done`.
- Same digest, HEX_ASCII=0, APPEND_CRLF=0 → 32 bytes, first 0xBA, last 0xAD; Busy high throughout, Ready low throughout.
- Transmitter model with `i_Tx_Done` high for 2 cycles and cleanup delay → no DV is asserted while `i_Tx_Done`=1 or `i_Tx_Active`=1; byte count exact.
- Digest 0x00…0F (last nibble 0xF) → last hex chars 0x30,0x66; nibble 9 → 0x39 and nibble A → 0x61 boundary checked.
- Valid pulsed mid-frame with a different digest → ignored; the frame output is unchanged.
- `i_Rst_n` low during byte 10 → all outputs return to reset values asynchronously; a new digest after release starts at byte 0.

Source files
------------

// File: rtl/sha_digest_uart_serializer.sv
// Streams a captured SHA digest to a UART transmitter one byte per handshake,
// as raw bytes or lowercase ASCII hex, optionally followed by CR/LF.
module sha_digest_uart_serializer #(
    parameter int DIGEST_WIDTH    = 256,
    parameter int UART_DATA_WIDTH = 8,
    parameter bit HEX_ASCII       = 1'b1,
    parameter bit APPEND_CRLF     = 1'b1
) (
    input  logic                       i_Clock,
    input  logic                       i_Rst_n,
    input  logic                       i_Digest_Valid,
    input  logic [DIGEST_WIDTH-1:0]    i_Digest,
    output logic                       o_Digest_Ready,
    output logic                       o_Tx_DV,
    output logic [UART_DATA_WIDTH-1:0] o_Tx_Byte,
    input  logic                       i_Tx_Active,
    input  logic                       i_Tx_Done,
    output logic                       o_Busy,
    output logic                       o_Frame_Done
);

    localparam int PAYLOAD = HEX_ASCII ? DIGEST_WIDTH / 4 : DIGEST_WIDTH / 8;
    localparam int NCHARS  = PAYLOAD + (APPEND_CRLF ? 2 : 0);
    localparam int CNT_W   = ($clog2(NCHARS) > 7) ? $clog2(NCHARS) : 7;
    localparam int STEP    = HEX_ASCII ? 4 : 8;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEND, S_WAIT_DONE, S_WAIT_IDLE, S_FINISH
    } state_t;

    state_t                  state, state_nxt;
    logic [DIGEST_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]        char_cnt;
    logic                    capture;
    logic                    advance;
    logic                    last_char;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
    endfunction

    // Once the payload is exhausted the counter selects CR, then LF.
    function automatic logic [7:0] form_char(input logic [7:0] top, input logic [CNT_W-1:0] cnt);
        if (cnt < CNT_W'(PAYLOAD))
            return HEX_ASCII ? hex_char(top[7:4]) : top;
        else if (cnt == CNT_W'(PAYLOAD))
            return 8'h0D;
        else
            return 8'h0A;
    endfunction

    assign last_char = (char_cnt == CNT_W'(NCHARS - 1));

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        advance   = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_Digest_Valid) begin
                    capture   = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD:      state_nxt = S_SEND;
            S_SEND:      state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (i_Tx_Done) state_nxt = S_WAIT_IDLE;
            // Done may linger; waiting for both low lands us in transmitter idle.
            S_WAIT_IDLE: begin
                if (!i_Tx_Done && !i_Tx_Active) begin
                    advance   = 1'b1;
                    state_nxt = last_char ? S_FINISH : S_LOAD;
                end
            end
            S_FINISH:    state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            char_cnt  <= '0;
            o_Tx_Byte <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                shift_reg <= i_Digest;
                char_cnt  <= '0;
            end else if (advance) begin
                shift_reg <= shift_reg << STEP;
                char_cnt  <= char_cnt + 1'b1;
            end
            if (state == S_LOAD)
                o_Tx_Byte <= UART_DATA_WIDTH'(form_char(shift_reg[DIGEST_WIDTH-1 -: 8], char_cnt));
        end
    end

    assign o_Digest_Ready = (state == S_IDLE);
    assign o_Tx_DV        = (state == S_SEND);
    assign o_Busy         = (state != S_IDLE);
    assign o_Frame_Done   = (state == S_FINISH);

endmodule

// File: tb/tb_sha_digest_uart_serializer.sv
// Bench for sha_digest_uart_serializer: hex+CRLF and raw instances driven by a
// transmitter model, bytes compared against a queue filled when a digest is offered.
module tb_sha_digest_uart_serializer;

    localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EDGE_D = 256'h9a00000000000000000000000000000000000000000000000000000000000f;

    logic         clk;
    logic         rst_n;
    logic         valid_h, valid_r;
    logic [255:0] digest;
    logic         active, done;
    logic         ready_h, dv_h, busy_h, fd_h;
    logic         ready_r, dv_r, busy_r, fd_r;
    logic [7:0]   byte_h, byte_r;
    logic         sel;

    logic         ready, dv, busy, fdone;
    logic [7:0]   txb;

    int checks, errors;
    int cyc, busy_bad;
    bit track;
    logic [7:0] q[$];

    sha_digest_uart_serializer dut_hex (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Digest_Valid(valid_h), .i_Digest(digest),
        .o_Digest_Ready(ready_h), .o_Tx_DV(dv_h), .o_Tx_Byte(byte_h),
        .i_Tx_Active(active), .i_Tx_Done(done), .o_Busy(busy_h), .o_Frame_Done(fd_h)
    );

    sha_digest_uart_serializer #(.HEX_ASCII(1'b0), .APPEND_CRLF(1'b0)) dut_raw (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Digest_Valid(valid_r), .i_Digest(digest),
        .o_Digest_Ready(ready_r), .o_Tx_DV(dv_r), .o_Tx_Byte(byte_r),
        .i_Tx_Active(active), .i_Tx_Done(done), .o_Busy(busy_r), .o_Frame_Done(fd_r)
    );

    assign ready = sel ? ready_r : ready_h;
    assign dv    = sel ? dv_r    : dv_h;
    assign busy  = sel ? busy_r  : busy_h;
    assign fdone = sel ? fd_r    : fd_h;
    assign txb   = sel ? byte_r  : byte_h;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (track && (busy !== 1'b1 || ready !== 1'b0)) busy_bad++;
    endtask

    task automatic set_valid(input bit v);
        if (sel) valid_r = v;
        else     valid_h = v;
    endtask

    task automatic push_expected(input bit raw, input logic [255:0] d);
        string s;
        if (raw) begin
            for (int i = 0; i < 32; i++) q.push_back(d[255 - 8*i -: 8]);
        end else begin
            s = $sformatf("%064x", d);
            for (int i = 0; i < 64; i++) q.push_back(s[i]);
            q.push_back(8'h0D);
            q.push_back(8'h0A);
        end
    endtask

    // abort_at < 0 runs the whole frame; glitch offers another digest mid-frame.
    task automatic run_frame(input bit raw, input logic [255:0] d, input int done_len,
                             input int cleanup, input int abort_at, input bit glitch,
                             output bit aborted);
        int nbytes, viol, gap_bad, fd, first_lat, w, nexp;
        bit timeout, finished;
        nbytes = 0; viol = 0; gap_bad = 0; fd = 0; first_lat = -1;
        timeout = 0; finished = 0; aborted = 0;
        nexp = raw ? 32 : 66;
        sel = raw;
        q.delete();
        push_expected(raw, d);
        digest = d;
        set_valid(1'b1);
        cyc = 0; busy_bad = 0;
        tick();
        set_valid(1'b0);
        track = 1;
        while (!finished && !timeout) begin
            w = 0;
            while (!dv && !fdone && w < 100) begin
                tick();
                w++;
            end
            if (fdone) begin
                fd++;
                finished = 1;
            end else if (!dv) begin
                timeout = 1;
            end else begin
                if (nbytes == 0) first_lat = cyc;
                else if (w != 2) gap_bad++;
                if (q.size() == 0) check("extra_byte", 1, 0);
                else check("byte", int'(txb), int'(q.pop_front()));
                nbytes++;
                if (nbytes - 1 == abort_at) begin
                    aborted = 1;
                    track = 0;
                    return;
                end
                active = 1'b1;
                if (glitch && nbytes == 6) begin
                    digest = ~d;
                    set_valid(1'b1);
                end
                repeat (3) begin tick(); if (dv) viol++; end
                done = 1'b1;
                active = (cleanup > 0);
                repeat (done_len) begin tick(); if (dv) viol++; end
                done = 1'b0;
                active = 1'b1;
                repeat (cleanup) begin tick(); if (dv) viol++; end
                set_valid(1'b0);
                active = 1'b0;
            end
        end
        track = 0;
        check("timeout", int'(timeout), 0);
        check("byte_count", nbytes, nexp);
        check("queue_left", q.size(), 0);
        check("frame_done_count", fd, 1);
        check("dv_while_tx_busy", viol, 0);
        check("inter_byte_gap", gap_bad, 0);
        check("first_dv_latency", first_lat, 2);
        check("busy_ready_in_frame", busy_bad, 0);
        tick();
        check("ready_after_frame", int'(ready), 1);
        check("busy_after_frame", int'(busy), 0);
        check("frame_done_single", int'(fdone), 0);
    endtask

    initial begin
        bit ab;
        logic [255:0] rnd;
        checks = 0; errors = 0; cyc = 0; busy_bad = 0; track = 0;
        rst_n = 1'b0; valid_h = 1'b0; valid_r = 1'b0; digest = '0;
        active = 1'b0; done = 1'b0; sel = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_dv", int'(dv), 0);
        check("rst_tx_byte", int'(txb), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(fdone), 0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", int'(ready), 1);
        check("ready_raw_after_rst", int'(ready_r), 1);

        run_frame(1'b0, ABC, 2, 0, -1, 1'b0, ab);
        run_frame(1'b1, ABC, 2, 0, -1, 1'b0, ab);
        run_frame(1'b0, EDGE_D, 2, 4, -1, 1'b0, ab);
        run_frame(1'b1, EDGE_D, 1, 2, -1, 1'b0, ab);

        for (int i = 0; i < 8; i++) rnd[32*i +: 32] = $urandom;
        run_frame(1'b0, rnd, 2, 1, -1, 1'b1, ab);

        run_frame(1'b0, ABC, 2, 0, 10, 1'b0, ab);
        check("abort_reached", int'(ab), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_tx_dv", int'(dv), 0);
        check("midrst_tx_byte", int'(txb), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_frame_done", int'(fdone), 0);
        check("midrst_ready", int'(ready), 1);
        q.delete();
        active = 1'b0; done = 1'b0; valid_h = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_frame(1'b0, rnd, 2, 0, -1, 1'b0, ab);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
